// File: rtl/pdm_audio_tx.sv
// PCM-to-PDM audio transmitter.
// Takes signed PCM samples through a one-deep valid/ready queue, generates the
// PDM bit clock (mclk) and drives a first-order sigma-delta bit stream.
// pdm_out is updated on the last clk cycle of each mclk period, which lies
// inside the mclk low phase, so the value is stable when mclk rises.
// When no new sample is queued at a frame boundary, the current sample repeats.
module pdm_audio_tx #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4,
    parameter int OSR     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] pcm_data,
    input  logic              pcm_valid,
    output logic              pcm_ready,
    output logic              mclk,
    output logic              pdm_out,
    output logic              done,
    output logic              underrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (OSR > 1) ? $clog2(OSR) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    // Signed two's complement to offset binary: flip the sign bit.
    function automatic logic [DATA_W-1:0] to_offset_binary(input logic [DATA_W-1:0] s);
        return {~s[DATA_W-1], s[DATA_W-2:0]};
    endfunction

    logic [DIV_W-1:0]  div_cnt_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] cur_r;
    logic [DATA_W-1:0] next_r;
    logic              next_full_r;
    logic              mclk_r;
    logic              pdm_r;
    logic              done_r;
    logic              underrun_r;

    logic              bit_tick_s;
    logic              frame_end_s;
    logic              accept_s;
    logic [DATA_W-1:0] u_s;
    logic [DATA_W:0]   sum_s;

    // Tick, frame boundary, handshake acceptance and modulator sum for this cycle.
    always_comb begin
        bit_tick_s  = 1'b0;
        frame_end_s = 1'b0;
        accept_s    = 1'b0;
        u_s         = {DATA_W{1'b0}};
        sum_s       = {(DATA_W + 1){1'b0}};

        bit_tick_s  = enable & (div_cnt_r == DIV_LAST);
        frame_end_s = bit_tick_s & (bit_cnt_r == BIT_LAST);
        accept_s    = pcm_valid & ~next_full_r;
        u_s         = to_offset_binary(cur_r);
        sum_s       = {1'b0, acc_r} + {1'b0, u_s};
    end

    // Clock divider and registered mclk; enable low parks both at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r <= {DIV_W{1'b0}};
            mclk_r    <= 1'b0;
        end else if (!enable) begin
            div_cnt_r <= {DIV_W{1'b0}};
            mclk_r    <= 1'b0;
        end else begin
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r <= {DIV_W{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + DIV_ONE;
            end
            mclk_r <= (div_cnt_r < DIV_HALF);
        end
    end

    // Bit counter and first-order sigma-delta accumulator, advanced once per PDM bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_r <= {BIT_W{1'b0}};
            acc_r     <= {DATA_W{1'b0}};
            pdm_r     <= 1'b0;
        end else if (!enable) begin
            bit_cnt_r <= {BIT_W{1'b0}};
            acc_r     <= {DATA_W{1'b0}};
            pdm_r     <= 1'b0;
        end else if (bit_tick_s) begin
            acc_r <= sum_s[DATA_W-1:0];
            pdm_r <= sum_s[DATA_W];
            if (bit_cnt_r == BIT_LAST) begin
                bit_cnt_r <= {BIT_W{1'b0}};
            end else begin
                bit_cnt_r <= bit_cnt_r + BIT_ONE;
            end
        end else begin
            bit_cnt_r <= bit_cnt_r;
            acc_r     <= acc_r;
            pdm_r     <= pdm_r;
        end
    end

    // Sample queue: accept into next, move next to cur at a frame boundary, flag done/underrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_r       <= {DATA_W{1'b0}};
            next_r      <= {DATA_W{1'b0}};
            next_full_r <= 1'b0;
            done_r      <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            done_r     <= frame_end_s & next_full_r;
            underrun_r <= frame_end_s & ~next_full_r;
            // Accept only happens while empty, load only while full: never both.
            if (frame_end_s && next_full_r) begin
                cur_r       <= next_r;
                next_full_r <= 1'b0;
            end else if (accept_s) begin
                next_r      <= pcm_data;
                next_full_r <= 1'b1;
            end else begin
                cur_r       <= cur_r;
                next_r      <= next_r;
                next_full_r <= next_full_r;
            end
        end
    end

    assign pcm_ready = ~next_full_r;
    assign mclk      = mclk_r;
    assign pdm_out   = pdm_r;
    assign done      = done_r;
    assign underrun  = underrun_r;

endmodule
